// File: rtl/fastram_cycle_ctrl.sv
// fastram_cycle_ctrl: 68000 bus-cycle front end for the fast-RAM window.
// Requests the SDRAM controller via ACCESS, then answers the CPU with DTACK, or with BERR if the controller stalls.
module fastram_cycle_ctrl #(
   parameter logic [2:0] BASE    = 3'b001,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        AS,
   input  logic        UDS,
   input  logic        LDS,
   input  logic        RW,
   input  logic [23:1] A,
   input  logic        ENABLE,
   input  logic        VALID,
   input  logic        WTERM,
   output logic        ACCESS,
   output logic        DTACK,
   output logic        BERR,
   output logic        DLATCH,
   output logic        DBUF_OE
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_R,
      WAIT_W,
      LATCH,
      ACK,
      ERR,
      DONE
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       as_meta;
   logic       as_s;
   logic       rw_q;
   logic       rw_next;
   logic [7:0] wd;
   logic [7:0] wd_next;
   logic       hit;
   logic       access_d;
   logic       dtack_d;
   logic       berr_d;
   logic       dlatch_d;
   logic       dbuf_oe_d;
   logic       unused_addr;

   assign hit         = ENABLE && (A[23:21] == BASE);
   assign unused_addr = ^A[20:1];

   // AS is asynchronous to CLK; only the second flop feeds decisions
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         as_meta <= 1'b1;
         as_s    <= 1'b1;
      end else begin
         as_meta <= AS;
         as_s    <= as_meta;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         wd      <= 8'd0;
         rw_q    <= 1'b1;
         ACCESS  <= 1'b1;
         DTACK   <= 1'b1;
         BERR    <= 1'b1;
         DLATCH  <= 1'b0;
         DBUF_OE <= 1'b1;
      end else begin
         state   <= next_state;
         wd      <= wd_next;
         rw_q    <= rw_next;
         ACCESS  <= access_d;
         DTACK   <= dtack_d;
         BERR    <= berr_d;
         DLATCH  <= dlatch_d;
         DBUF_OE <= dbuf_oe_d;
      end
   end

   always_comb begin
      next_state = state;
      wd_next    = wd;
      rw_next    = rw_q;
      access_d   = 1'b1;
      dtack_d    = 1'b1;
      berr_d     = 1'b1;
      dlatch_d   = 1'b0;
      dbuf_oe_d  = 1'b1;

      // A rising AS_S aborts any wait; VALID beats an expiring watchdog
      case (state)
         IDLE: begin
            if (!as_s) begin
               rw_next    = RW;
               next_state = hit ? REQ : DONE;
            end
         end
         REQ: begin
            wd_next    = TIMEOUT;
            next_state = rw_q ? WAIT_R : WAIT_W;
         end
         WAIT_R: begin
            if (as_s)
               next_state = IDLE;
            else if (!VALID)
               next_state = LATCH;
            else if (wd == 8'd0)
               next_state = ERR;
            else
               wd_next = wd - 8'd1;
         end
         WAIT_W: begin
            if (as_s)
               next_state = IDLE;
            else if (!WTERM && !(UDS && LDS))
               next_state = ACK;
            else if (wd == 8'd0)
               next_state = ERR;
            else
               wd_next = wd - 8'd1;
         end
         LATCH: begin
            next_state = as_s ? IDLE : ACK;
         end
         ACK, ERR, DONE: begin
            if (as_s)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase

      // Outputs are registered from the next state so they switch on the same edge as the state
      case (next_state)
         REQ, WAIT_R, WAIT_W: access_d = 1'b0;
         LATCH: begin
            access_d = 1'b0;
            dlatch_d = 1'b1;
         end
         ACK: begin
            access_d = 1'b0;
            dtack_d  = 1'b0;
         end
         ERR:     berr_d = 1'b0;
         default: access_d = 1'b1;
      endcase
      dbuf_oe_d = access_d;
   end

endmodule

// File: tb/tb_fastram_cycle_ctrl.sv
// Self-checking bench for fastram_cycle_ctrl: randomized bus cycles scored against
// per-edge expectations derived from the event timing of each access.
module tb_fastram_cycle_ctrl;
   localparam int TMO   = 10;
   localparam int NE    = 2048;
   localparam int BIG   = 1000000;
   localparam int T_ERR = 5 + TMO;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        AS = 1'b1;
   logic        UDS = 1'b1;
   logic        LDS = 1'b1;
   logic        RW = 1'b1;
   logic        ENABLE = 1'b1;
   logic        VALID = 1'b1;
   logic        WTERM = 1'b1;
   logic [23:0] addr = 24'h0;
   logic [23:1] A;
   logic        ACCESS, DTACK, BERR, DLATCH, DBUF_OE;
   logic [4:0]  obs;

   int checks = 0;
   int failures = 0;
   int ecnt = 0;

   // Stimulus applied just after edge e, and expected outputs just after edge e
   logic       s_as[NE];
   logic       s_valid[NE];
   logic       s_wterm[NE];
   logic [1:0] s_strb[NE];
   logic       x_acc[NE];
   logic       x_dtk[NE];
   logic       x_berr[NE];
   logic       x_dl[NE];

   assign A   = addr[23:1];
   assign obs = {ACCESS, DTACK, BERR, DLATCH, DBUF_OE};

   fastram_cycle_ctrl #(.BASE(3'b001), .TIMEOUT(8'(TMO))) dut (
      .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .A(A),
      .ENABLE(ENABLE), .VALID(VALID), .WTERM(WTERM), .ACCESS(ACCESS),
      .DTACK(DTACK), .BERR(BERR), .DLATCH(DLATCH), .DBUF_OE(DBUF_OE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "bench time limit");
   end

   function automatic logic [4:0] want(input int e);
      return {x_acc[e], x_dtk[e], x_berr[e], x_dl[e], x_acc[e]};
   endfunction

   // One AS cycle starting just after edge e0 (AS low from e0 to e0+r-1). v / s are the
   // edges after which VALID / the strobes go low. Expectations from the bus timing rules:
   // ACCESS low 3 edges after AS falls, release 3 edges after AS rises, read completes
   // one edge after VALID is seen in the wait (earliest edge 5), BERR at edge 5+TIMEOUT.
   function automatic void plan_txn(input int e0, input bit hit, input bit rd,
                                    input int v, input int s, input logic [1:0] sp,
                                    input int r);
      int c;
      int rr;
      rr = r + 3;
      for (int e = e0; e < e0 + r; e++) s_as[e] = 1'b0;
      if (rd) begin
         if (v < r + 2) for (int e = e0 + v; e <= e0 + r + 2; e++) s_valid[e] = 1'b0;
         c = (v < r + 2) ? ((v + 1 > 5) ? v + 1 : 5) : BIG;
      end else begin
         for (int e = e0; e <= e0 + r + 2; e++) s_wterm[e] = 1'b0;
         if (s < r + 2) for (int e = e0 + s; e <= e0 + r + 2; e++) s_strb[e] = sp;
         c = (s < r + 2) ? ((s + 1 > 5) ? s + 1 : 5) : BIG;
      end
      if (!hit) return;
      if (rr <= c && rr <= T_ERR) begin
         for (int e = e0 + 3; e < e0 + rr; e++) x_acc[e] = 1'b0;
      end else if (c <= T_ERR) begin
         for (int e = e0 + 3; e < e0 + rr; e++) x_acc[e] = 1'b0;
         if (rd) begin
            x_dl[e0 + c] = 1'b1;
            for (int e = e0 + c + 1; e < e0 + rr; e++) x_dtk[e] = 1'b0;
         end else begin
            for (int e = e0 + c; e < e0 + rr; e++) x_dtk[e] = 1'b0;
         end
      end else begin
         for (int e = e0 + 3; e < e0 + T_ERR; e++) x_acc[e] = 1'b0;
         for (int e = e0 + T_ERR; e < e0 + rr; e++) x_berr[e] = 1'b0;
      end
   endfunction

   task automatic apply_sched(input int e);
      AS    = s_as[e];
      VALID = s_valid[e];
      WTERM = s_wterm[e];
      {UDS, LDS} = s_strb[e];
   endtask

   task automatic step();
      @(posedge CLK);
      ecnt++;
      #1;
      apply_sched(ecnt);
   endtask

   function automatic logic [1:0] rand_strobes();
      logic [1:0] p;
      p = 2'($urandom_range(2, 0));
      return p;
   endfunction

   task automatic test_reset();
      #2 RST = 1'b0;
      AS = 1'b0;
      #1;
      checks++;
      if (obs !== 5'b11101) begin
         failures++;
         $display("FAIL reset_async got=%b want=11101", obs);
      end
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (obs !== 5'b11101) begin
         failures++;
         $display("FAIL reset_hold got=%b want=11101", obs);
      end
      AS = 1'b1;
      #2 RST = 1'b1;
      repeat (4) begin
         step();
         @(negedge CLK);
         checks++;
         if (obs !== want(ecnt)) begin
            failures++;
            $display("FAIL reset_idle edge=%0d got=%b want=%b", ecnt, obs, want(ecnt));
         end
      end
   endtask

   task automatic test_read_hit();
      int v, r, e0, pulses;
      for (int n = 0; n < 6; n++) begin
         v = (n == 0) ? 9 : int'($urandom_range(14, 0));
         r = (n == 0) ? 16 : v + int'($urandom_range(12, 4));
         addr = (n == 0) ? 24'h200000 : {3'b001, 21'($urandom)};
         ENABLE = 1'b1;
         RW = 1'b1;
         e0 = ecnt;
         plan_txn(e0, 1'b1, 1'b1, v, BIG, 2'b11, r);
         apply_sched(e0);
         pulses = 0;
         repeat (r + 6) begin
            step();
            @(negedge CLK);
            if (DLATCH === 1'b1) pulses++;
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL read_hit v=%0d r=%0d edge=+%0d got=%b want=%b", v, r, ecnt - e0, obs, want(ecnt));
            end
         end
         checks++;
         if (pulses != 1) begin
            failures++;
            $display("FAIL read_dlatch_pulses got=%0d want=1", pulses);
         end
      end
   endtask

   task automatic test_write_hit();
      int s, r, e0;
      logic [1:0] sp;
      for (int n = 0; n < 6; n++) begin
         s  = (n == 0) ? 7 : int'($urandom_range(14, 0));
         r  = (n == 0) ? 14 : s + int'($urandom_range(12, 3));
         sp = (n == 0) ? 2'b00 : rand_strobes();
         addr = {3'b001, 21'($urandom)};
         ENABLE = 1'b1;
         RW = 1'b0;
         e0 = ecnt;
         plan_txn(e0, 1'b1, 1'b0, BIG, s, sp, r);
         apply_sched(e0);
         repeat (r + 6) begin
            step();
            @(negedge CLK);
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL write_hit s=%0d r=%0d edge=+%0d got=%b want=%b", s, r, ecnt - e0, obs, want(ecnt));
            end
         end
      end
   endtask

   task automatic test_miss();
      int r, e0;
      logic [2:0] top;
      for (int n = 0; n < 5; n++) begin
         r = int'($urandom_range(12, 2));
         if (n == 0) begin
            addr = 24'h400000;
            ENABLE = 1'b1;
         end else if (n == 1) begin
            addr = 24'h200000;
            ENABLE = 1'b0;
         end else begin
            do top = 3'($urandom); while (top == 3'b001);
            addr = {top, 21'($urandom)};
            ENABLE = 1'b1;
         end
         RW = n[0];
         e0 = ecnt;
         plan_txn(e0, 1'b0, n[0], 2, 2, 2'b00, r);
         apply_sched(e0);
         repeat (r + 6) begin
            step();
            @(negedge CLK);
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL miss case=%0d edge=+%0d got=%b want=%b", n, ecnt - e0, obs, want(ecnt));
            end
         end
      end
      ENABLE = 1'b1;
   endtask

   task automatic test_timeout();
      int v, s, r, e0, first_berr;
      bit rd;
      for (int n = 0; n < 4; n++) begin
         rd = (n != 1);
         v  = (n == 3) ? T_ERR - 1 : BIG;
         s  = BIG;
         r  = (n == 0) ? 20 : (n == 3) ? 30 : int'($urandom_range(25, 13));
         addr = {3'b001, 21'($urandom)};
         RW = rd;
         e0 = ecnt;
         plan_txn(e0, 1'b1, rd, v, s, 2'b00, r);
         apply_sched(e0);
         first_berr = -1;
         repeat (r + 6) begin
            step();
            @(negedge CLK);
            if (BERR === 1'b0 && first_berr < 0) first_berr = ecnt - e0;
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL timeout case=%0d edge=+%0d got=%b want=%b", n, ecnt - e0, obs, want(ecnt));
            end
         end
         if (n == 0) begin
            checks++;
            if (first_berr - 4 != TMO + 1) begin
               failures++;
               $display("FAIL timeout_latency got=%0d want=%0d", first_berr - 4, TMO + 1);
            end
         end
         if (n == 3) begin
            checks++;
            if (first_berr != -1) begin
               failures++;
               $display("FAIL valid_vs_timeout berr_at=%0d want=none", first_berr);
            end
         end
      end
   endtask

   task automatic test_abort();
      int v, s, r, e0, dtk_seen;
      bit rd;
      for (int n = 0; n < 5; n++) begin
         rd = (n != 1);
         if (n == 2) begin
            v = 8;
            r = 7;
         end else begin
            v = BIG;
            r = int'($urandom_range(12, 2));
         end
         s = BIG;
         addr = {3'b001, 21'($urandom)};
         RW = rd;
         e0 = ecnt;
         plan_txn(e0, 1'b1, rd, v, s, 2'b00, r);
         apply_sched(e0);
         dtk_seen = 0;
         repeat (r + 6) begin
            step();
            @(negedge CLK);
            if (DTACK === 1'b0) dtk_seen++;
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL abort case=%0d edge=+%0d got=%b want=%b", n, ecnt - e0, obs, want(ecnt));
            end
         end
         checks++;
         if (dtk_seen != 0) begin
            failures++;
            $display("FAIL abort_dtack cycles=%0d want=0", dtk_seen);
         end
      end
   endtask

   task automatic test_back_to_back();
      int v2, r2, e0, phase, gap;
      bit rd2;
      for (int n = 0; n < 3; n++) begin
         addr = 24'h200000;
         RW = 1'b1;
         e0 = ecnt;
         plan_txn(e0, 1'b1, 1'b1, 5, BIG, 2'b11, 12);
         apply_sched(e0);
         phase = 0;
         gap = 0;
         repeat (13) begin
            step();
            @(negedge CLK);
            if (ACCESS === 1'b0 && phase == 0) phase = 1;
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL b2b_first edge=+%0d got=%b want=%b", ecnt - e0, obs, want(ecnt));
            end
         end
         rd2 = $urandom_range(1, 0) == 1;
         v2  = int'($urandom_range(10, 0));
         r2  = v2 + 8;
         RW  = rd2;
         addr = {3'b001, 21'($urandom)};
         e0 = ecnt;
         plan_txn(e0, 1'b1, rd2, v2, v2, rand_strobes(), r2);
         apply_sched(e0);
         repeat (r2 + 6) begin
            step();
            @(negedge CLK);
            if (phase == 1 && ACCESS === 1'b1) phase = 2;
            if (phase == 2 && ACCESS === 1'b1) gap++;
            if (phase == 2 && ACCESS === 1'b0) phase = 3;
            checks++;
            if (obs !== want(ecnt)) begin
               failures++;
               $display("FAIL b2b_second rd=%0d edge=+%0d got=%b want=%b", rd2, ecnt - e0, obs, want(ecnt));
            end
         end
         checks++;
         if (phase != 3 || gap < 1) begin
            failures++;
            $display("FAIL b2b_access_gap phase=%0d gap=%0d want=gap>=1", phase, gap);
         end
      end
   endtask

   task automatic test_reset_in_ack();
      int e0;
      addr = 24'h200000;
      RW = 1'b1;
      e0 = ecnt;
      plan_txn(e0, 1'b1, 1'b1, 5, BIG, 2'b11, 40);
      apply_sched(e0);
      repeat (9) begin
         step();
         @(negedge CLK);
         checks++;
         if (obs !== want(ecnt)) begin
            failures++;
            $display("FAIL ack_before_reset edge=+%0d got=%b want=%b", ecnt - e0, obs, want(ecnt));
         end
      end
      #2 RST = 1'b0;
      #1;
      checks++;
      if (obs !== 5'b11101) begin
         failures++;
         $display("FAIL reset_in_ack got=%b want=11101", obs);
      end
      @(posedge CLK);
      @(negedge CLK);
      #2 RST = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (k <= 2) begin
            checks++;
            if (ACCESS !== 1'b1) begin
               failures++;
               $display("FAIL rerequest_early k=%0d got=%b want=1", k, ACCESS);
            end
         end
         if (k == 3) begin
            checks++;
            if ({ACCESS, DBUF_OE} !== 2'b00) begin
               failures++;
               $display("FAIL rerequest_start got=%b want=00", {ACCESS, DBUF_OE});
            end
         end
         if (k == 6) begin
            checks++;
            if (obs !== 5'b00100) begin
               failures++;
               $display("FAIL rerequest_ack got=%b want=00100", obs);
            end
            AS = 1'b1;
            VALID = 1'b1;
         end
         if (k == 8) begin
            checks++;
            if (DTACK !== 1'b0) begin
               failures++;
               $display("FAIL release_early got=%b want=0", DTACK);
            end
         end
         if (k == 9) begin
            checks++;
            if (obs !== 5'b11101) begin
               failures++;
               $display("FAIL release got=%b want=11101", obs);
            end
         end
      end
   endtask

   initial begin
      for (int e = 0; e < NE; e++) begin
         s_as[e] = 1'b1;
         s_valid[e] = 1'b1;
         s_wterm[e] = 1'b1;
         s_strb[e] = 2'b11;
         x_acc[e] = 1'b1;
         x_dtk[e] = 1'b1;
         x_berr[e] = 1'b1;
         x_dl[e] = 1'b0;
      end
      test_reset();
      test_read_hit();
      test_write_hit();
      test_miss();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_reset_in_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
